// File: rtl/multiseg_counter.sv
// Cascaded DIGITS-wide counter plus a multiplexed seg10 display scanner.
// Optional feature: define MULTISEG_BLANK_LEADING_EN to blank leading zero digits.
module multiseg_counter #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 10,
    parameter int SCAN_W     = 4,
    parameter int MAX_DIGIT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              clear,
    output logic              LED,
    output logic              sync,
    output logic              wrap,
    output logic [DIGITS-1:0] dig_sel,
    output logic [9:0]        segs
);

    localparam int         IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] MAXD  = 4'(MAX_DIGIT);

    // Local copy of the seg10 decoder table (segment a in bit 0).
    function automatic logic [9:0] seg10(input logic [3:0] v);
        logic [9:0] s;
        s = '0;
        case (v)
            4'h0: s = 10'h03F;
            4'h1: s = 10'h006;
            4'h2: s = 10'h05B;
            4'h3: s = 10'h04F;
            4'h4: s = 10'h066;
            4'h5: s = 10'h06D;
            4'h6: s = 10'h07D;
            4'h7: s = 10'h007;
            4'h8: s = 10'h07F;
            4'h9: s = 10'h06F;
            4'hA: s = 10'h077;
            4'hB: s = 10'h07C;
            4'hC: s = 10'h039;
            4'hD: s = 10'h05E;
            4'hE: s = 10'h079;
            4'hF: s = 10'h071;
            default: s = '0;
        endcase
        return s;
    endfunction

    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic [DIGITS-1:0][3:0]  digits_q, digits_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wrap_q, wrap_d;
    logic [DIGITS-1:0]       dig_sel_q, dig_sel_d;
    logic [9:0]              segs_q, segs_d;
    logic                    tick, scan_tick, cy;
    logic [3:0]              cur;

    assign pre_d     = pre_q + 1'b1;
    assign tick      = &pre_q;
    assign scan_tick = &pre_q[SCAN_W-1:0];

    // Ripple carry/borrow across digits; a carry out of the top digit is the wrap.
    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        cy       = 1'b1;
        if (clear) begin
            digits_d = '0;
        end else if (tick && en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (cy) begin
                    if (up) begin
                        if (digits_q[i] == MAXD) digits_d[i] = 4'd0;
                        else begin
                            digits_d[i] = digits_q[i] + 4'd1;
                            cy          = 1'b0;
                        end
                    end else begin
                        if (digits_q[i] == 4'd0) digits_d[i] = MAXD;
                        else begin
                            digits_d[i] = digits_q[i] - 4'd1;
                            cy          = 1'b0;
                        end
                    end
                end
            end
            wrap_d = cy;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (scan_tick) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Select and pattern are both built from pre-edge idx, so they stay aligned.
    always_comb begin
        cur       = 4'd0;
        dig_sel_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur          = digits_q[i];
                dig_sel_d[i] = 1'b1;
            end
        end
        segs_d = seg10(cur);
`ifdef MULTISEG_BLANK_LEADING_EN
        if ((cur == 4'd0) && (idx_q != '0)) begin
            segs_d = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if ((IDX_W'(i) > idx_q) && (digits_q[i] != 4'd0)) segs_d = seg10(cur);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            digits_q  <= '0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            dig_sel_q <= '0;
            segs_q    <= '0;
        end else begin
            pre_q     <= pre_d;
            digits_q  <= digits_d;
            idx_q     <= idx_d;
            wrap_q    <= wrap_d;
            dig_sel_q <= dig_sel_d;
            segs_q    <= segs_d;
        end
    end

    assign LED     = pre_q[PRESCALE_W-1];
    assign sync    = (digits_q == '0);
    assign wrap    = wrap_q;
    assign dig_sel = dig_sel_q;
    assign segs    = segs_q;

endmodule

// File: tb/tb_multiseg_counter.sv
// Directed bench: four small counter instances sharing clock and reset, each with its own controls.
module tb_multiseg_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] en = '0, up = '0, clr = '0;
    int         total = 0, passed = 0;

    logic       d2_led, d2_sync, d2_wrap;  logic [1:0] d2_sel; logic [9:0] d2_segs;
    logic       h2_led, h2_sync, h2_wrap;  logic [1:0] h2_sel; logic [9:0] h2_segs;
    logic       h4_led, h4_sync, h4_wrap;  logic [3:0] h4_sel; logic [9:0] h4_segs;
    logic       s4_led, s4_sync, s4_wrap;  logic [3:0] s4_sel; logic [9:0] s4_segs;

    logic       which = 1'b0;
    logic [3:0] sel_o;
    logic [9:0] segs_o;
    assign sel_o  = which ? h4_sel : s4_sel;
    assign segs_o = which ? h4_segs : s4_segs;

    localparam logic [9:0] SEG0 = 10'h03F, SEG1 = 10'h006, SEG2 = 10'h05B,
                           SEG3 = 10'h04F, SEG5 = 10'h06D;

    always #5 clk = ~clk;

    multiseg_counter #(.DIGITS(2), .PRESCALE_W(2), .SCAN_W(1), .MAX_DIGIT(9)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .up(up[0]), .clear(clr[0]),
        .LED(d2_led), .sync(d2_sync), .wrap(d2_wrap), .dig_sel(d2_sel), .segs(d2_segs));
    multiseg_counter #(.DIGITS(2), .PRESCALE_W(2), .SCAN_W(1), .MAX_DIGIT(15)) u_h2 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .up(up[1]), .clear(clr[1]),
        .LED(h2_led), .sync(h2_sync), .wrap(h2_wrap), .dig_sel(h2_sel), .segs(h2_segs));
    multiseg_counter #(.DIGITS(4), .PRESCALE_W(2), .SCAN_W(1), .MAX_DIGIT(15)) u_h4 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .up(up[2]), .clear(clr[2]),
        .LED(h4_led), .sync(h4_sync), .wrap(h4_wrap), .dig_sel(h4_sel), .segs(h4_segs));
    multiseg_counter #(.DIGITS(4), .PRESCALE_W(2), .SCAN_W(1), .MAX_DIGIT(3)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en(en[3]), .up(up[3]), .clear(clr[3]),
        .LED(s4_led), .sync(s4_sync), .wrap(s4_wrap), .dig_sel(s4_sel), .segs(s4_segs));

    // Reference prescaler: the edge following pre_m == 3 is a count tick.
    logic [1:0] pre_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_m <= 2'd0;
        else        pre_m <= pre_m + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pre3();
        for (int k = 0; k < 8 && pre_m != 2'd3; k++) step();
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            wait_pre3();
            step();
        end
    endtask

    // Sync to the first cycle of dig_sel == 0001, then check 8 cycles of scan.
    task automatic scan_check(input string tag, input logic [3:0][9:0] ex);
        logic [3:0] prev;
        prev = sel_o;
        for (int k = 0; k < 16; k++) begin
            step();
            if (prev == 4'b1000 && sel_o == 4'b0001) break;
            prev = sel_o;
        end
        chk({tag, "_align"}, sel_o, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk({tag, "_sel"}, sel_o, 32'(4'b0001 << (k / 2)));
            chk({tag, "_segs"}, segs_o, ex[k/2]);
        end
    endtask

    initial begin
        logic [3:0][9:0] ex;

        // Reset held for three edges
        repeat (3) step();
        chk("rst_sel",  h4_sel, 4'b0000);
        chk("rst_segs", h4_segs, 10'h000);
        chk("rst_wrap", h4_wrap, 1'b0);
        chk("rst_sync", h4_sync, 1'b1);
        chk("rst_led",  h4_led, 1'b0);
        chk("rst_dig",  u_h4.digits_q, 16'h0000);
        rst_n = 1'b1;
        step();
        chk("start_sel4", h4_sel, 4'b0001);
        chk("start_seg4", h4_segs, SEG0);
        chk("start_sel2", d2_sel, 2'b01);

        // Decimal up count with carry and full wrap
        en[0] = 1'b1; up[0] = 1'b1;
        tick_n(9);
        chk("dec_09", u_d2.digits_q, 8'h09);
        tick_n(1);
        chk("dec_10", u_d2.digits_q, 8'h10);
        chk("dec_10_sync", d2_sync, 1'b0);
        chk("dec_10_wrap", d2_wrap, 1'b0);
        tick_n(89);
        chk("dec_99", u_d2.digits_q, 8'h99);
        tick_n(1);
        chk("dec_00", u_d2.digits_q, 8'h00);
        chk("dec_wrap", d2_wrap, 1'b1);
        chk("dec_sync", d2_sync, 1'b1);
        step();
        chk("dec_wrap_pulse", d2_wrap, 1'b0);
        en[0] = 1'b0;

        // Hex down count with borrow and full wrap
        en[1] = 1'b1; up[1] = 1'b0;
        tick_n(1);
        chk("hex_ff", u_h2.digits_q, 8'hFF);
        chk("hex_wrap", h2_wrap, 1'b1);
        chk("hex_sync", h2_sync, 1'b0);
        tick_n(8'hEF);
        chk("hex_10", u_h2.digits_q, 8'h10);
        tick_n(1);
        chk("hex_0f", u_h2.digits_q, 8'h0F);
        chk("hex_0f_wrap", h2_wrap, 1'b0);

        // Clear beats a tick
        up[1] = 1'b1;
        tick_n(8'h28);
        chk("clr_37", u_h2.digits_q, 8'h37);
        wait_pre3();
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("clr_00", u_h2.digits_q, 8'h00);
        chk("clr_wrap", h2_wrap, 1'b0);
        tick_n(1);
        chk("clr_01", u_h2.digits_q, 8'h01);

        // Enable low freezes digits but not the prescaler or scan
        en[1] = 1'b0;
        tick_n(3);
        chk("hold_01", u_h2.digits_q, 8'h01);
        chk("hold_led", h2_led, pre_m[1]);
        step();
        chk("hold_led2", h2_led, pre_m[1]);

        // Scan multiplex on digits 3,2,1,0
        en[3] = 1'b1; up[3] = 1'b1;
        tick_n(228);
        en[3] = 1'b0;
        chk("scan_val", u_s4.digits_q, 16'h3210);
        which = 1'b0;
        ex[0] = SEG0; ex[1] = SEG1; ex[2] = SEG2; ex[3] = SEG3;
        scan_check("scan", ex);

        // Leading-zero handling at 0005 and 0000
        en[2] = 1'b1; up[2] = 1'b1;
        tick_n(5);
        en[2] = 1'b0;
        chk("blank_val", u_h4.digits_q, 16'h0005);
        which = 1'b1;
`ifdef MULTISEG_BLANK_LEADING_EN
        ex[0] = SEG5; ex[1] = 10'h000; ex[2] = 10'h000; ex[3] = 10'h000;
`else
        ex[0] = SEG5; ex[1] = SEG0; ex[2] = SEG0; ex[3] = SEG0;
`endif
        scan_check("blank5", ex);
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        chk("blank_clr", u_h4.digits_q, 16'h0000);
`ifdef MULTISEG_BLANK_LEADING_EN
        ex[0] = SEG0; ex[1] = 10'h000; ex[2] = 10'h000; ex[3] = 10'h000;
`else
        ex[0] = SEG0; ex[1] = SEG0; ex[2] = SEG0; ex[3] = SEG0;
`endif
        scan_check("blank0", ex);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multiseg_counter.md
# multiseg_counter

Parametrised multi-digit counter and multiplexed segment-display driver for the icestick multisegment board. A free-running prescaler produces a count tick and a digit-scan tick. The tick advances a cascaded DIGITS-wide counter with a selectable radix, up or down. Each digit is decoded through the existing `seg10` decoder and time-multiplexed onto one shared segment bus with a one-hot digit select, replacing the single-digit top-level counter.

## Interface
- `DIGITS`, 4, number of cascaded digits; range 1..8.
- `PRESCALE_W`, 10, prescaler width in bits; count tick period is 2^PRESCALE_W cycles; range 2..24.
- `SCAN_W`, 4, scan divider width; scan tick period is 2^SCAN_W cycles; must satisfy 1 ≤ SCAN_W ≤ PRESCALE_W.
- `MAX_DIGIT`, 15, highest value of each digit before carry; 9 gives decimal, 15 gives hex; range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  count enable; gates count ticks only.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `clear`  in  1  synchronous clear of all digits.
- `LED`  out  1  prescaler MSB (heartbeat).
- `sync`  out  1  high while every digit is 0.
- `wrap`  out  1  one-cycle pulse after the whole counter rolls over.
- `dig_sel`  out  DIGITS  one-hot active-high digit enable; registered.
- `segs`  out  10  `seg10` pattern for the selected digit; registered.

## Operation
- Prescaler `pre[PRESCALE_W-1:0]` increments every cycle, wraps modulo 2^PRESCALE_W, and ignores `en`.
- `tick` = (pre == all ones). `scan_tick` = (pre[SCAN_W-1:0] == all ones).
- Digit update priority, highest first:
  - `clear` → all digits 0, no `wrap`.
  - `tick & en & up` → digit 0 increments. Any digit at MAX_DIGIT with carry-in goes to 0 and carries to the next digit.
  - `tick & en & !up` → digit 0 decrements. Any digit at 0 with borrow-in goes to MAX_DIGIT and borrows from the next digit.
  - otherwise hold.
- Overall wrap:
  - Up: all digits MAX_DIGIT → all 0, `wrap` = 1 for one cycle.
  - Down: all digits 0 → all MAX_DIGIT, `wrap` = 1 for one cycle.
- Digits are 4 bits and never exceed MAX_DIGIT.
- Scan index `idx` advances on `scan_tick`, from 0 to DIGITS-1, then back to 0.
- On every edge, `dig_sel` ← onehot(idx) and `segs` ← seg10(digit[idx]). Both come from the same pre-edge values, so they are always aligned.
- `sync` is combinational from the digit registers.
- `LED` = pre[PRESCALE_W-1].

## Timing
- Reset, asynchronous on `rst_n` low: pre = 0, digits = 0, idx = 0, `wrap` = 0, `dig_sel` = 0 (all off), `segs` = 0. Consequently `sync` = 1 and `LED` = 0.
- Reset released mid-count restarts the prescaler from 0. The first `tick` then occurs 2^PRESCALE_W - 1 edges after release.
- Digit change is visible 1 cycle after the `tick` edge. `wrap` is asserted in that same cycle.
- Display latency: a digit change appears on `segs` 1 cycle later, when that digit is the one selected.
- `en` or `up` changing on a `tick` cycle uses the pre-edge values.
- `clear` together with `tick` → clear wins.
- When `tick` is true, `scan_tick` is also true (same edge); both take effect.
- DIGITS = 1: `dig_sel` is constant 1 after the first edge, and `idx` is fixed at 0.

## Configuration
- `MULTISEG_BLANK_LEADING_EN` defined: leading-zero blanking is on.
  - If digit[idx] is 0, idx > 0, and every digit above idx is 0, then `segs` ← 0 while `dig_sel` still selects that digit.
  - Digit 0 is never blanked.
- Not defined: every digit always shows its `seg10` pattern. No blanking logic is synthesised.

## Test plan
- Reset/startup:
  - Stimulus: `rst_n` = 0 for 3 cycles, then release.
  - Required: all outputs at their reset values during reset; `sync` = 1; `dig_sel` = 0001 after the first edge.
- Decimal carry, up count:
  - Stimulus: PRESCALE_W = 2, MAX_DIGIT = 9, DIGITS = 2, `en` = 1, `up` = 1, counter preloaded by counting to 09.
  - Required: the next tick gives 10.
  - Required: from 99, the next tick gives 00 with one `wrap` pulse, and `sync` = 1.
- Hex down count and borrow:
  - Stimulus: MAX_DIGIT = 15, DIGITS = 2, `up` = 0, starting at 00.
  - Required: the next tick gives FF with `wrap` = 1; from 10, the next tick gives 0F.
- Clear priority:
  - Stimulus: assert `clear` on a `tick` cycle while the counter is 0x37.
  - Required: digits are 00 on the next cycle and `wrap` = 0.
  - Stimulus: `en` = 0 for 3 ticks.
  - Required: digits unchanged while the prescaler and scan keep running.
- Scan multiplex:
  - Stimulus: SCAN_W = 1, DIGITS = 4, digits 3,2,1,0.
  - Required: `dig_sel` cycles 0001 → 0010 → 0100 → 1000, changing every 2 cycles.
  - Required: `segs` equals seg10(0), seg10(1), seg10(2), seg10(3) respectively, each aligned with its `dig_sel` value.
- Blanking, with `MULTISEG_BLANK_LEADING_EN` defined, value 0005, DIGITS = 4:
  - Required: `segs` = 0 for digits 3..1 and seg10(5) for digit 0.
  - Required: at value 0000, digit 0 shows seg10(0).
  - Required: with the macro undefined, all digits show their `seg10` pattern.
